// File: rtl/holy_control_pkg.sv
// rtl/holy_control_pkg.sv - shared states, opcodes and control encodings for multicycle_control
package holy_control_pkg;

  typedef enum logic [3:0] {
    BOOT, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  function automatic logic [1:0] imm_source_of(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - decoded-instruction inputs and datapath strobes of the control FSM
interface multicycle_control_if;
  logic [6:0] op;
  logic [2:0] func3;
  logic       func7_b5;
  logic       alu_zero;
  logic       alu_lt;
  logic       mem_ack;
  logic       mem_req;
  logic       mem_we;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] imm_source;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic [2:0] alu_control;
  logic       illegal;

  modport master (
    input  op, func3, func7_b5, alu_zero, alu_lt, mem_ack,
    output mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
           imm_source, alu_src_a, alu_src_b, result_src, alu_control, illegal
  );

  modport slave (
    output op, func3, func7_b5, alu_zero, alu_lt, mem_ack,
    input  mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
           imm_source, alu_src_a, alu_src_b, result_src, alu_control, illegal
  );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// rtl/multicycle_control_alu_decoder.sv - maps op/func3/func7_b5 to an ALU operation and flags unsupported func3
module alu_decoder
  import holy_control_pkg::*;
(
  input  logic [6:0] op_i,
  input  logic [2:0] func3_i,
  input  logic       func7_b5_i,
  output logic [2:0] alu_control_o,
  output logic       unsupported_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    unsupported_o = 1'b0;
    if (op_i == OP_R || op_i == OP_I) begin
      case (func3_i)
        3'b000:  alu_control_o = (op_i == OP_R && func7_b5_i) ? ALU_SUB : ALU_ADD;
        3'b010:  alu_control_o = ALU_SLT;
        3'b110:  alu_control_o = ALU_OR;
        3'b111:  alu_control_o = ALU_AND;
        default: unsupported_o = 1'b1;
      endcase
    end else if (op_i == OP_BRANCH) begin
      // Branches compare by subtraction; only BEQ/BNE/BLT/BGE exist.
      alu_control_o = ALU_SUB;
      case (func3_i)
        3'b000, 3'b001, 3'b100, 3'b101: unsupported_o = 1'b0;
        default:                        unsupported_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM sequencing the shared ALU and memory port
module multicycle_control
  import holy_control_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  multicycle_control_if.master   bus
);

  state_t     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic [2:0] dec_alu_control;
  logic       dec_unsupported;
  logic       taken;

  alu_decoder u_alu_decoder (
    .op_i          (bus.op),
    .func3_i       (bus.func3),
    .func7_b5_i    (bus.func7_b5),
    .alu_control_o (dec_alu_control),
    .unsupported_o (dec_unsupported)
  );

  always_comb begin
    taken = 1'b0;
    case (bus.func3)
      3'b000:  taken = bus.alu_zero;
      3'b001:  taken = !bus.alu_zero;
      3'b100:  taken = bus.alu_lt;
      3'b101:  taken = !bus.alu_lt;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BOOT;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  assign illegal_d   = illegal_q | (state_d == TRAP);
  assign bus.illegal = illegal_q;

  always_comb begin
    state_d         = state_q;
    bus.mem_req     = 1'b0;
    bus.mem_we      = 1'b0;
    bus.adr_src     = 1'b0;
    bus.ir_write    = 1'b0;
    bus.pc_write    = 1'b0;
    bus.reg_write   = 1'b0;
    bus.imm_source  = (state_q == BOOT) ? IMM_I : imm_source_of(bus.op);
    bus.alu_src_a   = SRCA_PC;
    bus.alu_src_b   = SRCB_RD2;
    bus.result_src  = RES_ALUOUT;
    bus.alu_control = ALU_ADD;

    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        bus.mem_req    = 1'b1;
        bus.alu_src_b  = SRCB_FOUR;
        bus.result_src = RES_ALU;
        if (bus.mem_ack) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          state_d      = DECODE;
        end
      end
      DECODE: begin
        // old PC + imm lands in alu_out ahead of BRANCH/JAL
        bus.alu_src_a = SRCA_OLDPC;
        bus.alu_src_b = SRCB_IMM;
        case (bus.op)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_R:      state_d = dec_unsupported ? TRAP : EXEC_R;
          OP_I:      state_d = dec_unsupported ? TRAP : EXEC_I;
          OP_BRANCH: state_d = dec_unsupported ? TRAP : BRANCH;
          OP_JAL:    state_d = JAL;
          default:   state_d = TRAP;
        endcase
      end
      MEMADR: begin
        bus.alu_src_a = SRCA_RD1;
        bus.alu_src_b = SRCB_IMM;
        state_d       = (bus.op == OP_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        bus.mem_req = 1'b1;
        bus.adr_src = 1'b1;
        if (bus.mem_ack) state_d = MEMWB;
      end
      MEMWB: begin
        bus.result_src = RES_MEM;
        bus.reg_write  = 1'b1;
        state_d        = FETCH;
      end
      MEMWRITE: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
        bus.adr_src = 1'b1;
        if (bus.mem_ack) state_d = FETCH;
      end
      EXEC_R: begin
        bus.alu_src_a   = SRCA_RD1;
        bus.alu_src_b   = SRCB_RD2;
        bus.alu_control = dec_alu_control;
        state_d         = ALUWB;
      end
      EXEC_I: begin
        bus.alu_src_a   = SRCA_RD1;
        bus.alu_src_b   = SRCB_IMM;
        bus.alu_control = dec_alu_control;
        state_d         = ALUWB;
      end
      ALUWB: begin
        bus.reg_write = 1'b1;
        state_d       = FETCH;
      end
      BRANCH: begin
        bus.alu_src_a   = SRCA_RD1;
        bus.alu_src_b   = SRCB_RD2;
        bus.alu_control = ALU_SUB;
        bus.pc_write    = taken;
        state_d         = FETCH;
      end
      JAL: begin
        // PC takes the target from alu_out; ALU meanwhile forms old PC + 4 for rd
        bus.alu_src_a = SRCA_OLDPC;
        bus.alu_src_b = SRCB_FOUR;
        bus.pc_write  = 1'b1;
        state_d       = ALUWB;
      end
      TRAP:    state_d = TRAP;
      default: state_d = BOOT;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control against a per-instruction trace model
module tb_multicycle_control;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_control_if bus ();
  multicycle_control dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int passed = 0;
  int total  = 0;

  // {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, illegal, imm, src_a, src_b, result, alu}
  wire [17:0] obs_w = {bus.mem_req, bus.mem_we, bus.adr_src, bus.ir_write, bus.pc_write,
                       bus.reg_write, bus.illegal, bus.imm_source, bus.alu_src_a,
                       bus.alu_src_b, bus.result_src, bus.alu_control};

  logic [18:0] trace[$];  // {mem_ack to drive, expected outputs}
  logic [17:0] got[$];

  function automatic logic [17:0] ev(bit req, bit we, bit adr, bit irw, bit pcw, bit rw, bit ill,
                                     logic [1:0] imm, logic [1:0] sa, logic [1:0] sb,
                                     logic [1:0] rs, logic [2:0] alu);
    return {req, we, adr, irw, pcw, rw, ill, imm, sa, sb, rs, alu};
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [1:0] imm_of(logic [6:0] op);
    if (op == 7'b0100011) return 2'b01;
    if (op == 7'b1100011) return 2'b10;
    if (op == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  function automatic bit legal(logic [6:0] op, logic [2:0] f3);
    if (op == 7'b0110011 || op == 7'b0010011)
      return f3 == 3'b000 || f3 == 3'b010 || f3 == 3'b110 || f3 == 3'b111;
    if (op == 7'b1100011)
      return f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b100 || f3 == 3'b101;
    return op == 7'b0000011 || op == 7'b0100011 || op == 7'b1101111;
  endfunction

  function automatic logic [2:0] alu_of(logic [6:0] op, logic [2:0] f3, bit f7);
    if (f3 == 3'b010) return 3'b101;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b111) return 3'b010;
    return (op == 7'b0110011 && f7) ? 3'b001 : 3'b000;
  endfunction

  function automatic bit taken_of(logic [2:0] f3, bit z, bit lt);
    if (f3 == 3'b000) return z;
    if (f3 == 3'b001) return !z;
    if (f3 == 3'b100) return lt;
    return !lt;
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction starting in the fetch phase.
  function automatic void build_trace(logic [6:0] op, logic [2:0] f3, bit f7, bit z, bit lt,
                                      int fw, int mw);
    logic [1:0]  im = imm_of(op);
    logic [17:0] acc;
    trace.delete();
    for (int i = 0; i < fw; i++) trace.push_back({1'b0, ev(1,0,0,0,0,0,0,im,2'b00,2'b10,2'b10,3'b000)});
    trace.push_back({1'b1, ev(1,0,0,1,1,0,0,im,2'b00,2'b10,2'b10,3'b000)});
    trace.push_back({rb(), ev(0,0,0,0,0,0,0,im,2'b01,2'b01,2'b00,3'b000)});
    if (!legal(op, f3)) begin
      trace.push_back({rb(), ev(0,0,0,0,0,0,1,im,2'b00,2'b00,2'b00,3'b000)});
      return;
    end
    case (op)
      7'b0000011, 7'b0100011: begin
        trace.push_back({rb(), ev(0,0,0,0,0,0,0,im,2'b10,2'b01,2'b00,3'b000)});
        acc = ev(1, op == 7'b0100011, 1,0,0,0,0,im,2'b00,2'b00,2'b00,3'b000);
        for (int i = 0; i < mw; i++) trace.push_back({1'b0, acc});
        trace.push_back({1'b1, acc});
        if (op == 7'b0000011)
          trace.push_back({rb(), ev(0,0,0,0,0,1,0,im,2'b00,2'b00,2'b01,3'b000)});
      end
      7'b0110011, 7'b0010011: begin
        trace.push_back({rb(), ev(0,0,0,0,0,0,0,im,2'b10, (op == 7'b0010011) ? 2'b01 : 2'b00,
                                  2'b00, alu_of(op, f3, f7))});
        trace.push_back({rb(), ev(0,0,0,0,0,1,0,im,2'b00,2'b00,2'b00,3'b000)});
      end
      7'b1100011:
        trace.push_back({rb(), ev(0,0,0,0,taken_of(f3, z, lt),0,0,im,2'b10,2'b00,2'b00,3'b001)});
      default: begin
        trace.push_back({rb(), ev(0,0,0,0,1,0,0,im,2'b01,2'b10,2'b00,3'b000)});
        trace.push_back({rb(), ev(0,0,0,0,0,1,0,im,2'b00,2'b00,2'b00,3'b000)});
      end
    endcase
  endfunction

  // Drives one instruction through the DUT and records its outputs; called at a falling edge.
  task automatic play(input logic [6:0] op, input logic [2:0] f3, input bit f7, input bit z,
                      input bit lt, input int fw, input int mw);
    build_trace(op, f3, f7, z, lt, fw, mw);
    got.delete();
    foreach (trace[k]) begin
      bus.op = op; bus.func3 = f3; bus.func7_b5 = f7;
      bus.alu_zero = z; bus.alu_lt = lt; bus.mem_ack = trace[k][18];
      #1;
      got.push_back(obs_w);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [17:0] fetch_idle = ev(1,0,0,0,0,0,0,2'b00,2'b00,2'b10,2'b10,3'b000);
    rst_n = 1'b0;
    bus.op = 7'd0; bus.func3 = 3'd0; bus.func7_b5 = 1'b0;
    bus.alu_zero = 1'b0; bus.alu_lt = 1'b0; bus.mem_ack = 1'b1;
    repeat (2) @(negedge clk);
    #1; total++;
    if (obs_w !== 18'd0) $display("FAIL reset_held got %h expected %h", obs_w, 18'd0); else passed++;
    @(negedge clk); rst_n = 1'b1; #1; total++;
    if (obs_w !== 18'd0) $display("FAIL boot_cycle got %h expected %h", obs_w, 18'd0); else passed++;
    @(negedge clk); bus.mem_ack = 1'b0; #1; total++;
    if (obs_w !== fetch_idle) $display("FAIL first_fetch got %h expected %h", obs_w, fetch_idle); else passed++;
    #3; rst_n = 1'b0; #1; total++;
    if (obs_w !== 18'd0) $display("FAIL reset_mid_fetch got %h expected %h", obs_w, 18'd0); else passed++;
    bus.mem_ack = 1'b1;
    @(negedge clk); rst_n = 1'b1; #1; total++;
    if (obs_w !== 18'd0) $display("FAIL ack_after_reset got %h expected %h", obs_w, 18'd0); else passed++;
    @(negedge clk); bus.mem_ack = 1'b0; #1; total++;
    if (obs_w !== fetch_idle) $display("FAIL refetch got %h expected %h", obs_w, fetch_idle); else passed++;
    @(negedge clk);
  endtask

  task automatic test_add_rtype();
    play(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 3, 0);
    foreach (trace[k]) begin
      total++;
      if (got[k] !== trace[k][17:0]) $display("FAIL add_r step %0d got %h expected %h", k, got[k], trace[k][17:0]);
      else passed++;
    end
  endtask

  task automatic test_load_store();
    play(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 0, 0);
    foreach (trace[k]) begin
      total++;
      if (got[k] !== trace[k][17:0]) $display("FAIL load step %0d got %h expected %h", k, got[k], trace[k][17:0]);
      else passed++;
    end
    play(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 1, 1);
    foreach (trace[k]) begin
      total++;
      if (got[k] !== trace[k][17:0]) $display("FAIL store step %0d got %h expected %h", k, got[k], trace[k][17:0]);
      else passed++;
    end
  endtask

  task automatic test_branch_jal();
    logic [6:0] ops [4] = '{7'b1100011, 7'b1100011, 7'b1100011, 7'b1101111};
    logic [2:0] f3s [4] = '{3'b001, 3'b001, 3'b100, 3'b000};
    bit         zs  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    bit         lts [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int c = 0; c < 4; c++) begin
      play(ops[c], f3s[c], 1'b0, zs[c], lts[c], c % 2, 0);
      foreach (trace[k]) begin
        total++;
        if (got[k] !== trace[k][17:0])
          $display("FAIL branch_jal case %0d step %0d got %h expected %h", c, k, got[k], trace[k][17:0]);
        else passed++;
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [6] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
    logic [2:0] alu_f3 [4] = '{3'b000, 3'b010, 3'b110, 3'b111};
    logic [2:0] br_f3  [4] = '{3'b000, 3'b001, 3'b100, 3'b101};
    for (int n = 0; n < 40; n++) begin
      logic [6:0] op = ops[$urandom_range(0, 5)];
      logic [2:0] f3 = 3'($urandom_range(0, 7));
      if (op == 7'b0110011 || op == 7'b0010011) f3 = alu_f3[$urandom_range(0, 3)];
      if (op == 7'b1100011) f3 = br_f3[$urandom_range(0, 3)];
      play(op, f3, rb(), rb(), rb(), $urandom_range(0, 3), $urandom_range(0, 3));
      foreach (trace[k]) begin
        total++;
        if (got[k] !== trace[k][17:0])
          $display("FAIL random instr %0d op %b f3 %b step %0d got %h expected %h",
                   n, op, f3, k, got[k], trace[k][17:0]);
        else passed++;
      end
    end
  endtask

  task automatic test_trap();
    logic [6:0] ops [2] = '{7'b1110011, 7'b0110011};
    logic [2:0] f3s [2] = '{3'b000, 3'b001};
    for (int c = 0; c < 2; c++) begin
      play(ops[c], f3s[c], 1'b0, 1'b0, 1'b0, 1, 0);
      foreach (trace[k]) begin
        total++;
        if (got[k] !== trace[k][17:0])
          $display("FAIL trap_entry case %0d step %0d got %h expected %h", c, k, got[k], trace[k][17:0]);
        else passed++;
      end
      for (int i = 0; i < 4; i++) begin
        bus.mem_ack = rb(); #1; total++;
        if (obs_w !== ev(0,0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000))
          $display("FAIL trap_hold case %0d cycle %0d got %h expected %h", c, i, obs_w,
                   ev(0,0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000));
        else passed++;
        @(negedge clk);
      end
      #2; rst_n = 1'b0; #1; total++;
      if (bus.illegal !== 1'b0 || obs_w !== 18'd0)
        $display("FAIL trap_async_reset case %0d got %h expected %h", c, obs_w, 18'd0);
      else passed++;
      @(negedge clk); rst_n = 1'b1; #1; total++;
      if (obs_w !== 18'd0) $display("FAIL trap_boot case %0d got %h expected %h", c, obs_w, 18'd0);
      else passed++;
      @(negedge clk);
    end
    play(7'b0010011, 3'b110, 1'b1, 1'b0, 1'b0, 0, 0);
    foreach (trace[k]) begin
      total++;
      if (got[k] !== trace[k][17:0]) $display("FAIL post_trap_ori step %0d got %h expected %h", k, got[k], trace[k][17:0]);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_add_rtype();
    test_load_store();
    test_branch_jal();
    test_random();
    test_trap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
